comb_decimator_2: RTL and testbench



---
 rtl/comb_decimator_2_pkg.sv | 16 +
 rtl/comb_decimator_2_if.sv | 15 +
 rtl/comb_decimator_2_comb_stage.sv | 29 ++
 rtl/comb_decimator_2.sv | 114 +++++++++++
 tb/tb_comb_decimator_2.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/comb_decimator_2_pkg.sv
// Shared constants and warm-up FSM encoding for the incremental-ADC decimation filter.
package iadc_filter_pkg;
    localparam int IN_W_DEFAULT = 18;
    localparam int OSR_DEFAULT  = 16;

    typedef enum logic [1:0] {WARM0, WARM1, RUN} warm_state_t;

    // Each stage-2 update moves one step closer to a complete comb history.
    function automatic warm_state_t warm_next(input warm_state_t s);
        case (s)
            WARM0:   return WARM1;
            WARM1:   return RUN;
            default: return RUN;
        endcase
    endfunction
endpackage

// File: rtl/comb_decimator_2_if.sv
// Sample/result bundle between integrator, comb decimator and readout logic.
interface comb_decimator_2_if #(parameter int IN_W = iadc_filter_pkg::IN_W_DEFAULT);
    logic            en;
    logic            clr;
    logic [IN_W-1:0] data_in;
    logic [IN_W-1:0] data_out;
    logic            valid_out;
    logic            ready_in;
    logic            overrun;

    modport master (output en, clr, data_in, ready_in,
                    input  data_out, valid_out, overrun);
    modport slave  (input  en, clr, data_in, ready_in,
                    output data_out, valid_out, overrun);
endinterface

// File: rtl/comb_decimator_2_comb_stage.sv
// Registered first difference: on en_i, dout <= din - previous din (modulo 2^W).
module comb_stage #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o
);
    logic [W-1:0] hist_q;
    logic [W-1:0] dout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            dout_q <= '0;
        end else if (clr_i) begin
            hist_q <= '0;
            dout_q <= '0;
        end else if (en_i) begin
            hist_q <= din_i;
            dout_q <= din_i - hist_q;
        end
    end

    assign dout_o = dout_q;
endmodule

// File: rtl/comb_decimator_2.sv
// 2nd-order CIC comb + decimate-by-OSR; result 2 cycles after the decimation tick.
// No stall: an unaccepted result is overwritten and flagged by sticky overrun.
module comb_decimator_2
    import iadc_filter_pkg::*;
#(
    parameter int IN_W  = IN_W_DEFAULT,
    parameter int OSR   = OSR_DEFAULT,
    parameter int CNT_W = $clog2(OSR)
) (
    input  logic               clk,
    input  logic               rst,
    comb_decimator_2_if.slave  dec_if
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IN_W-1:0]  x_q;
    logic             tag1_q, tag2_q;
    logic [IN_W-1:0]  c1;
    logic [IN_W-1:0]  dout;
    warm_state_t      state_q, state_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             tick;

    assign tick = dec_if.en && (cnt_q == CNT_W'(OSR - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (dec_if.clr)
            cnt_d = '0;
        else if (tick)
            cnt_d = '0;
        else if (dec_if.en)
            cnt_d = cnt_q + CNT_W'(1);
    end

    // tag1/tag2 mark which pipeline stage holds live data for this tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            x_q    <= '0;
            tag1_q <= 1'b0;
            tag2_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (dec_if.clr) begin
                x_q    <= '0;
                tag1_q <= 1'b0;
                tag2_q <= 1'b0;
            end else begin
                if (tick)
                    x_q <= dec_if.data_in;
                tag1_q <= tick;
                tag2_q <= tag1_q;
            end
        end
    end

    comb_stage #(.W(IN_W)) u_stage1 (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (dec_if.clr),
        .en_i   (tag1_q),
        .din_i  (x_q),
        .dout_o (c1)
    );

    comb_stage #(.W(IN_W)) u_stage2 (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (dec_if.clr),
        .en_i   (tag2_q),
        .din_i  (c1),
        .dout_o (dout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WARM0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (dec_if.clr) begin
            state_d = WARM0;
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            if (valid_q && dec_if.ready_in)
                valid_d = 1'b0;
            if (tag2_q) begin
                state_d = warm_next(state_q);
                // Warm-up updates still load data_out but never present it.
                if (state_q == RUN) begin
                    if (valid_q && !dec_if.ready_in)
                        ovr_d = 1'b1;
                    valid_d = 1'b1;
                end
            end
        end
    end

    assign dec_if.data_out  = dout;
    assign dec_if.valid_out = valid_q;
    assign dec_if.overrun   = ovr_q;
endmodule

// File: tb/tb_comb_decimator_2.sv
// Directed + random bench for comb_decimator_2 against a sample-level CIC comb model.
module tb_comb_decimator_2;
    import iadc_filter_pkg::*;

    localparam int W   = 18;
    localparam int OSR = 4;

    logic clk;
    logic rst;

    comb_decimator_2_if #(.IN_W(W)) bus ();

    comb_decimator_2 #(.IN_W(W), .OSR(OSR)) dut (
        .clk    (clk),
        .rst    (rst),
        .dec_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert;
    int n_fail;
    int cyc;

    // Model: decimated samples s_k, output y_k = s_k - 2 s_(k-1) + s_(k-2), zero history.
    int          m_ecnt;
    int          m_nsamp;
    logic [W-1:0] m_s1, m_s2;
    int          due_q[$];
    logic [W-1:0] val_q[$];
    bit          vf_q[$];
    logic [W-1:0] exp_data;
    bit          exp_valid;
    bit          exp_ovr;

    int got_val[$];
    int got_step[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_ecnt  = 0;
        m_nsamp = 0;
        m_s1    = '0;
        m_s2    = '0;
        due_q.delete();
        val_q.delete();
        vf_q.delete();
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
    endtask

    task automatic model_edge(input bit e, input logic [W-1:0] d, input bit r, input bit c);
        bit           old_valid;
        logic [W-1:0] y;
        if (c) begin
            model_reset();
            return;
        end
        old_valid = exp_valid;
        if (old_valid && r)
            exp_valid = 1'b0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            exp_data = val_q.pop_front();
            if (vf_q.pop_front()) begin
                if (old_valid && !r)
                    exp_ovr = 1'b1;
                exp_valid = 1'b1;
            end
        end
        if (e) begin
            if (m_ecnt == OSR - 1) begin
                y = d - (m_s1 << 1) + m_s2;
                due_q.push_back(cyc + 2);
                val_q.push_back(y);
                vf_q.push_back(m_nsamp >= 2);
                m_s2 = m_s1;
                m_s1 = d;
                m_nsamp++;
            end
            m_ecnt = (m_ecnt + 1) % OSR;
        end
    endtask

    task automatic chk_outputs();
        chk("data_out",  32'(bus.data_out),  32'(exp_data));
        chk("valid_out", 32'(bus.valid_out), 32'(exp_valid));
        chk("overrun",   32'(bus.overrun),   32'(exp_ovr));
    endtask

    task automatic step(input bit e, input logic [W-1:0] d, input bit r, input bit c);
        bus.en       = e;
        bus.data_in  = d;
        bus.ready_in = r;
        bus.clr      = c;
        @(posedge clk);
        #1;
        model_edge(e, d, r, c);
        cyc++;
        chk_outputs();
    endtask

    task automatic run_quad(input int nsteps, input bit gap, input bit rdy, input logic [W-1:0] off);
        int n;
        n = 0;
        got_val.delete();
        got_step.delete();
        for (int i = 0; i < nsteps; i++) begin
            bit           e;
            logic [W-1:0] d;
            e = gap ? (i % 2 == 0) : 1'b1;
            d = e ? W'(n * n + int'(off)) : W'($urandom);
            step(e, d, rdy, 1'b0);
            if (e) n++;
            if (bus.valid_out) begin
                got_val.push_back(int'(bus.data_out));
                got_step.push_back(i);
            end
        end
    endtask

    task automatic check_32s(input string tag);
        foreach (got_val[k])
            chk(tag, 32'(got_val[k]), 32'd32);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.clr      = 1'b0;
        bus.data_in  = '0;
        bus.ready_in = 1'b0;
        model_reset();
        #1;
        chk_outputs();
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;

        // Quadratic ramp: first valid 2 cycles after the 3rd tick, always 32.
        run_quad(24, 1'b0, 1'b1, '0);
        chk("quad_count", 32'(got_val.size()), 32'd3);
        if (got_step.size() > 0)
            chk("quad_first_step", 32'(got_step[0]), 32'(3 * OSR + 1));
        check_32s("quad_val");

        // Integrator wrap-around cancels exactly.
        step(1'b0, '0, 1'b1, 1'b1);
        run_quad(24, 1'b0, 1'b1, W'((1 << W) - 100));
        chk("wrap_count", 32'(got_val.size()), 32'd3);
        check_32s("wrap_val");

        // Gapped enable: same results, spaced 2*OSR clocks.
        step(1'b0, '0, 1'b1, 1'b1);
        run_quad(50, 1'b1, 1'b1, '0);
        chk("gap_count", 32'(got_val.size()), 32'd4);
        if (got_step.size() > 0)
            chk("gap_first_step", 32'(got_step[0]), 32'(6 * OSR));
        for (int k = 1; k < got_step.size(); k++)
            chk("gap_period", 32'(got_step[k] - got_step[k-1]), 32'(2 * OSR));
        check_32s("gap_val");

        // Backpressure across two RUN results, overrun sticky until clr.
        step(1'b0, '0, 1'b1, 1'b1);
        run_quad(18, 1'b0, 1'b0, '0);
        chk("bp_valid",   32'(bus.valid_out), 32'd1);
        chk("bp_overrun", 32'(bus.overrun),   32'd1);
        chk("bp_data",    32'(bus.data_out),  32'd32);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, '0, k == 3, 1'b0);
            chk("bp_sticky", 32'(bus.overrun), 32'd1);
        end
        step(1'b0, '0, 1'b0, 1'b1);
        chk("bp_clr_overrun", 32'(bus.overrun), 32'd0);

        // Clear one cycle after a RUN tick: that result never appears.
        step(1'b0, '0, 1'b1, 1'b1);
        run_quad(16, 1'b0, 1'b1, '0);
        step(1'b0, '0, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("clr_no_valid", 32'(bus.valid_out), 32'd0);
        end
        run_quad(24, 1'b0, 1'b1, '0);
        if (got_step.size() > 0)
            chk("clr_restart_step", 32'(got_step[0]), 32'(3 * OSR + 1));
        else
            chk("clr_restart_count", 32'(got_step.size()), 32'd3);
        check_32s("clr_restart_val");

        // Asynchronous reset mid-run: outputs zero without a clock edge.
        run_quad(10, 1'b0, 1'b0, '0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk_outputs();
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        run_quad(24, 1'b0, 1'b1, '0);
        chk("rst_count", 32'(got_val.size()), 32'd3);
        if (got_step.size() > 0)
            chk("rst_first_step", 32'(got_step[0]), 32'(3 * OSR + 1));
        check_32s("rst_val");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 49) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
